// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared definitions for the 7-segment scan receiver:
//   - SEG_0..SEG_F : active-high glyphs {a,b,c,d,e,f,g} for hex digits 0-F
//   - AN_*         : one-hot anode codes, AN_BLANK for the inter-digit blank
//   - digit_t      : 2-bit digit index (0 = leftmost digit, frame bits [27:21])
//   - state_t      : frame assembly FSM state encoding
//   - an_is_onehot / an_to_digit : anode decode helpers
// -----------------------------------------------------------------------------
package seg_scan_pkg;

  typedef logic [1:0] digit_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam logic [3:0] AN_BLANK = 4'b0000;
  localparam logic [3:0] AN_D0    = 4'b0001;
  localparam logic [3:0] AN_D1    = 4'b0010;
  localparam logic [3:0] AN_D2    = 4'b0100;
  localparam logic [3:0] AN_D3    = 4'b1000;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  // True when exactly one anode line is active.
  function automatic logic an_is_onehot(input logic [3:0] a);
    return (a != 4'b0000) && ((a & (a - 4'b0001)) == 4'b0000);
  endfunction

  // Digit index of a one-hot anode code; callers qualify with an_is_onehot.
  function automatic digit_t an_to_digit(input logic [3:0] a);
    digit_t d;
    case (a)
      AN_D0:   d = 2'd0;
      AN_D1:   d = 2'd1;
      AN_D2:   d = 2'd2;
      AN_D3:   d = 2'd3;
      default: d = 2'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// -----------------------------------------------------------------------------
// seg7_to_hex
// Combinational glyph -> hex nibble decoder. Unrecognised patterns give
// nibble 0 with invalid set. Only built when SEG_HEX_DECODE_EN is defined,
// since seg_scan_capture instantiates it only in that configuration.
// Ports:
//   seg     in  7  segment pattern {a,b,c,d,e,f,g}, active-high
//   nibble  out 4  decoded hex value (0 when invalid)
//   invalid out 1  pattern is not one of the 0-F glyphs
// -----------------------------------------------------------------------------
`ifdef SEG_HEX_DECODE_EN
module seg7_to_hex
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       invalid
);

  // Glyph lookup; anything outside the sixteen glyphs is flagged.
  always_comb begin
    nibble  = 4'h0;
    invalid = 1'b0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: begin
        nibble  = 4'h0;
        invalid = 1'b1;
      end
    endcase
  end

endmodule
`endif

// File: rtl/seg_scan_capture.sv
// -----------------------------------------------------------------------------
// seg_scan_capture
// Bus monitor for a 4-digit multiplexed 7-segment display. Registers the
// anode/segment lines, accepts a digit once it has been stable for
// STABLE_CYCLES samples, assembles digits 0..3 into a 28-bit frame and flags
// scan-order violations.
// Parameters:
//   STABLE_CYCLES  samples of identical {an,seg} needed to accept (1..15)
//   CNT_W          dwell counter width, must hold STABLE_CYCLES
// Ports:
//   clk          in   1   clock, rising edge
//   rst_n        in   1   synchronous reset, active-low
//   an           in   4   anode select, one-hot active-high
//   seg          in   7   segment pattern {a..g}, active-high
//   data_out     out  28  last complete frame {d0,d1,d2,d3}
//   frame_valid  out  1   pulse: data_out updated this cycle
//   frame_err    out  1   pulse: scan sequence violation
// Optional (macro SEG_HEX_DECODE_EN):
//   hex_out      out  16  decoded nibble per digit, d0 in [15:12]
//   hex_err      out  1   some digit of the frame was not a 0-F glyph
// -----------------------------------------------------------------------------
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [27:0] data_out,
  output logic        frame_valid,
  output logic        frame_err
`ifdef SEG_HEX_DECODE_EN
  ,
  output logic [15:0] hex_out,
  output logic        hex_err
`endif
);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};

  logic [10:0]      smp_r;
  logic [CNT_W-1:0] dwell_r;
  logic             done_r;
  state_t           state_r;
  digit_t           exp_r;
  logic [6:0]       slot0_r;
  logic [6:0]       slot1_r;
  logic [6:0]       slot2_r;

  logic [3:0]  smp_an_s;
  logic [6:0]  smp_seg_s;
  logic        new_dwell_s;
  logic        accept_s;
  logic        blank_s;
  logic        onehot_s;
  digit_t      digit_s;
  logic [27:0] frame_next_s;

  assign smp_an_s     = smp_r[10:7];
  assign smp_seg_s    = smp_r[6:0];
  // dwell_r == 0 only before the first sample after reset, which always
  // opens a dwell even if it matches the reset value of smp_r.
  assign new_dwell_s  = (dwell_r == '0) || ({an, seg} != smp_r);
  // done_r makes the accept one-shot even when the counter saturates at
  // the same value as STABLE_C.
  assign accept_s     = (dwell_r == STABLE_C) && !done_r;
  assign blank_s      = (smp_an_s == AN_BLANK);
  assign onehot_s     = an_is_onehot(smp_an_s);
  assign digit_s      = an_to_digit(smp_an_s);
  assign frame_next_s = {slot0_r, slot1_r, slot2_r, smp_seg_s};

  // Input sample register and per-dwell stability counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_r   <= 11'h000;
      dwell_r <= '0;
      done_r  <= 1'b0;
    end else begin
      smp_r <= {an, seg};
      if (new_dwell_s) begin
        dwell_r <= CNT_W'(1);
        done_r  <= 1'b0;
      end else begin
        if (dwell_r != DWELL_MAX) begin
          dwell_r <= dwell_r + CNT_W'(1);
        end
        done_r <= done_r | accept_s;
      end
    end
  end

`ifdef SEG_HEX_DECODE_EN
  logic [3:0]  nib_s [4];
  logic [3:0]  inv_s;
  logic [15:0] hex_next_s;

  for (genvar g = 0; g < 4; g++) begin : g_dec
    seg7_to_hex u_dec (
      .seg     (frame_next_s[27-7*g -: 7]),
      .nibble  (nib_s[g]),
      .invalid (inv_s[g])
    );
  end

  assign hex_next_s = {nib_s[0], nib_s[1], nib_s[2], nib_s[3]};

  // Decoded view of the frame, loaded together with data_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hex_out <= 16'h0000;
      hex_err <= 1'b0;
    end else if (accept_s && !blank_s && onehot_s &&
                 (state_r == ST_COLLECT) && (digit_s == exp_r) &&
                 (digit_s == 2'd3)) begin
      hex_out <= hex_next_s;
      hex_err <= |inv_s;
    end
  end
`endif

  // Frame assembly FSM with registered frame and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      exp_r       <= 2'd0;
      slot0_r     <= 7'h00;
      slot1_r     <= 7'h00;
      slot2_r     <= 7'h00;
      data_out    <= 28'h0000000;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (accept_s && !blank_s) begin
        if (!onehot_s) begin
          frame_err <= 1'b1;
          state_r   <= ST_IDLE;
        end else begin
          case (state_r)
            ST_IDLE: begin
              if (digit_s == 2'd0) begin
                slot0_r <= smp_seg_s;
                exp_r   <= 2'd1;
                state_r <= ST_COLLECT;
              end
            end
            ST_COLLECT: begin
              if (digit_s == exp_r) begin
                exp_r <= exp_r + 2'd1;
                case (digit_s)
                  2'd1: slot1_r <= smp_seg_s;
                  2'd2: slot2_r <= smp_seg_s;
                  2'd3: begin
                    data_out    <= frame_next_s;
                    frame_valid <= 1'b1;
                    state_r     <= ST_IDLE;
                  end
                  default: slot0_r <= smp_seg_s;
                endcase
              end else begin
                // Out-of-order digit; a digit 0 restarts the frame at once.
                frame_err <= 1'b1;
                if (digit_s == 2'd0) begin
                  slot0_r <= smp_seg_s;
                  exp_r   <= 2'd1;
                end else begin
                  state_r <= ST_IDLE;
                end
              end
            end
            default: state_r <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [27:0] d1, d3;
  logic        v1, v3, e1, e3;
`ifdef SEG_HEX_DECODE_EN
  logic [15:0] h1, h3;
  logic        he1, he3;
`endif

  seg_scan_capture #(.STABLE_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
    .data_out(d1), .frame_valid(v1), .frame_err(e1)
`ifdef SEG_HEX_DECODE_EN
    , .hex_out(h1), .hex_err(he1)
`endif
  );

  seg_scan_capture #(.STABLE_CYCLES(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
    .data_out(d3), .frame_valid(v3), .frame_err(e3)
`ifdef SEG_HEX_DECODE_EN
    , .hex_out(h3), .hex_err(he3)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b1;

  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model state, index 0 -> stability 1, index 1 -> stability 3.
  int          run_len [2];
  logic [10:0] run_val [2];
  bit          pend    [2];
  logic [6:0]  coll    [2][4];
  int          cnt     [2];
  bit          exp_v   [2];
  bit          exp_e   [2];
  logic [27:0] exp_d   [2];
  logic [15:0] exp_h   [2];
  bit          exp_he  [2];
  int          vcount  [2];
  int          ecount  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // An accepted sample, applied with the scan rules to the list of digits
  // collected so far.
  task automatic apply(input int i);
    logic [3:0] a;
    logic [6:0] s;
    int d;
    a = run_val[i][10:7];
    s = run_val[i][6:0];
    if (a == 4'b0000) return;
    if ($countones(a) != 1) begin
      exp_e[i] = 1'b1;
      cnt[i]   = 0;
      return;
    end
    d = 0;
    for (int k = 0; k < 4; k++) if (a[k]) d = k;
    if (d == cnt[i]) begin
      coll[i][d] = s;
      cnt[i]     = cnt[i] + 1;
      if (cnt[i] == 4) begin
        exp_v[i]  = 1'b1;
        exp_d[i]  = {coll[i][0], coll[i][1], coll[i][2], coll[i][3]};
        exp_h[i]  = 16'h0000;
        exp_he[i] = 1'b0;
        for (int g = 0; g < 4; g++) begin
          int n;
          n = -1;
          for (int t = 0; t < 16; t++) if (glyph[t] == coll[i][g]) n = t;
          if (n < 0) exp_he[i] = 1'b1;
          else exp_h[i][15-4*g -: 4] = 4'(n);
        end
        cnt[i] = 0;
      end
    end else if (cnt[i] > 0) begin
      exp_e[i] = 1'b1;
      if (d == 0) begin
        coll[i][0] = s;
        cnt[i]     = 1;
      end else begin
        cnt[i] = 0;
      end
    end
  endtask

  task automatic model_update(input int i);
    int stab;
    stab = (i == 0) ? 1 : 3;
    exp_v[i] = 1'b0;
    exp_e[i] = 1'b0;
    if (!rst_n) begin
      run_len[i] = 0;
      pend[i]    = 1'b0;
      cnt[i]     = 0;
      exp_d[i]   = 28'h0;
      exp_h[i]   = 16'h0;
      exp_he[i]  = 1'b0;
      return;
    end
    if (pend[i]) apply(i);
    if (run_len[i] == 0 || {an, seg} != run_val[i]) begin
      run_val[i] = {an, seg};
      run_len[i] = 1;
    end else begin
      run_len[i] = run_len[i] + 1;
    end
    pend[i] = (run_len[i] == stab);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_s1", 32'(v1), 32'(exp_v[0]));
      check("err_s1",   32'(e1), 32'(exp_e[0]));
      check("data_s1",  32'(d1), 32'(exp_d[0]));
      check("valid_s3", 32'(v3), 32'(exp_v[1]));
      check("err_s3",   32'(e3), 32'(exp_e[1]));
      check("data_s3",  32'(d3), 32'(exp_d[1]));
      check("excl_s1",  32'(v1 & e1), 32'd0);
`ifdef SEG_HEX_DECODE_EN
      check("hex_s1",    32'(h1),  32'(exp_h[0]));
      check("hexerr_s1", 32'(he1), 32'(exp_he[0]));
      check("hex_s3",    32'(h3),  32'(exp_h[1]));
      check("hexerr_s3", 32'(he3), 32'(exp_he[1]));
`endif
      if (v1) vcount[0]++;
      if (v3) vcount[1]++;
      if (e1) ecount[0]++;
      if (e3) ecount[1]++;
    end
  end

  task automatic step(input logic r, input logic [3:0] a, input logic [6:0] s);
    rst_n = r;
    an    = a;
    seg   = s;
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
  endtask

  task automatic digit(input int d, input logic [6:0] s, input int hold);
    logic [3:0] one;
    one = 4'b0001;
    for (int h = 0; h < hold; h++) step(1'b1, 4'(one << d), s);
  endtask

  task automatic blanks(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 4'b0000, 7'h00);
  endtask

  task automatic scan(input int hold);
    digit(0, 7'h7E, hold);
    digit(1, 7'h30, hold);
    digit(2, 7'h6D, hold);
    digit(3, 7'h79, hold);
  endtask

  int v0, v3c, e0, e3c;

  initial begin
    for (int i = 0; i < 2; i++) begin
      run_len[i] = 0; pend[i] = 1'b0; cnt[i] = 0;
      exp_v[i] = 1'b0; exp_e[i] = 1'b0; exp_d[i] = 28'h0;
      exp_h[i] = 16'h0; exp_he[i] = 1'b0; vcount[i] = 0; ecount[i] = 0;
    end

    // 1: reset
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0000, 7'h00);
    check("rst_data", 32'(d1), 32'd0);
    check("rst_valid", 32'(v1), 32'd0);
    check("rst_err", 32'(e1), 32'd0);

    // 2: back-to-back scans
    v0 = vcount[0]; v3c = vcount[1];
    for (int l = 0; l < 3; l++) scan(1);
    blanks(2);
    check("t2_data", 32'(d1), 32'h0FCC36F9);
    check("t2_model", 32'(exp_d[0]), 32'h0FCC36F9);
    check("t2_nvalid_s1", 32'(vcount[0] - v0), 32'd3);
    check("t2_nvalid_s3", 32'(vcount[1] - v3c), 32'd0);
`ifdef SEG_HEX_DECODE_EN
    check("t2_hex", 32'(h1), 32'h0123);
    check("t2_hexerr", 32'(he1), 32'd0);
`endif

    // 3: skipped digit
    v0 = vcount[0]; e0 = ecount[0];
    digit(0, 7'h7E, 1);
    digit(2, 7'h6D, 1);
    blanks(2);
    check("t3_err", 32'(ecount[0] - e0), 32'd1);
    check("t3_novalid", 32'(vcount[0] - v0), 32'd0);
    scan(1);
    blanks(2);
    check("t3_recover", 32'(vcount[0] - v0), 32'd1);

    // 4: multi-hot anode held, then blanking
    e0 = ecount[0]; e3c = ecount[1];
    for (int k = 0; k < 5; k++) step(1'b1, 4'b0011, 7'h00);
    blanks(3);
    check("t4_err_s1", 32'(ecount[0] - e0), 32'd1);
    check("t4_err_s3", 32'(ecount[1] - e3c), 32'd1);
    e0 = ecount[0];
    blanks(4);
    check("t4_blank", 32'(ecount[0] - e0), 32'd0);

    // 5: stability threshold of 3
    v0 = vcount[0]; v3c = vcount[1];
    scan(2);
    blanks(3);
    check("t5_h2_s3", 32'(vcount[1] - v3c), 32'd0);
    check("t5_h2_s1", 32'(vcount[0] - v0), 32'd1);
    scan(3);
    blanks(3);
    check("t5_h3_s3", 32'(vcount[1] - v3c), 32'd1);
    check("t5_h3_data", 32'(d3), 32'h0FCC36F9);

    // 6: reset mid-frame
    v0 = vcount[0]; v3c = vcount[1];
    digit(0, 7'h7E, 3);
    digit(1, 7'h30, 3);
    step(1'b0, 4'b0000, 7'h00);
    digit(2, 7'h6D, 3);
    digit(3, 7'h79, 3);
    blanks(3);
    check("t6_s1", 32'(vcount[0] - v0), 32'd0);
    check("t6_s3", 32'(vcount[1] - v3c), 32'd0);
    check("t6_data", 32'(d1), 32'd0);

`ifdef SEG_HEX_DECODE_EN
    // 7: non-glyph digit
    scan(1);
    blanks(2);
    check("t7_hex_ok", 32'(h1), 32'h0123);
    digit(0, 7'h7E, 1);
    digit(1, 7'h30, 1);
    digit(2, 7'h00, 1);
    digit(3, 7'h79, 1);
    blanks(2);
    check("t7_hex_bad", 32'(h1), 32'h0103);
    check("t7_hexerr", 32'(he1), 32'd1);
`endif

    // Randomised scans, glitches and resets against the model.
    for (int it = 0; it < 300; it++) begin
      int mode;
      mode = $urandom_range(0, 99);
      if (mode < 3) begin
        step(1'b0, 4'b0000, 7'h00);
      end else if (mode < 60) begin
        for (int d = 0; d < 4; d++) begin
          digit(d, glyph[$urandom_range(0, 15)], $urandom_range(1, 4));
          if ($urandom_range(0, 3) == 0) blanks($urandom_range(1, 3));
        end
      end else begin
        logic [3:0] a;
        int sel;
        sel = $urandom_range(0, 5);
        case (sel)
          0: a = 4'b0000;
          1: a = 4'b0001;
          2: a = 4'b0010;
          3: a = 4'b0100;
          4: a = 4'b1000;
          default: a = 4'($urandom_range(0, 15));
        endcase
        for (int h = 0; h < int'($urandom_range(1, 4)); h++)
          step(1'b1, a, 7'($urandom_range(0, 127)));
      end
    end
    blanks(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
